trap_controller: RTL and testbench
==================================

# trap_controller

Sequencer and port arbiter for the machine-mode CSR file. In idle it passes the core's Zicsr read/write port straight through. On a synchronous exception it takes the port and performs, in fixed order, the mepc write, the mcause write and the mtvec read, then redirects the PC. It handles MRET the same way by reading mepc back. It sits between the decode/execute stage and the CSR file and drives the PC-select and stall logic.

## Interface
Parameters:
- RESET_STATE, IDLE, FSM state entered on reset.

Ports:
- clk  in  1  system clock, rising-edge.
- reset  in  1  asynchronous, active-high reset.
- core_csr_read_address  in  12  Zicsr read address from the core.
- core_csr_write_enable  in  1  Zicsr write request.
- core_csr_write_address  in  12  Zicsr write address.
- core_csr_write_data  in  32  Zicsr write data.
- trap_pc  in  32  PC of the faulting instruction.
- exc_inst_misaligned / exc_illegal / exc_ebreak / exc_ecall / exc_load_misaligned / exc_store_misaligned  in  1 each  exception flags, single-cycle valid.
- mret  in  1  MRET retiring.
- csr_read_data  in  32  read data from the CSR file.
- csr_read_address  out  12  to the CSR file.
- csr_write_enable  out  1  to the CSR file.
- csr_write_address  out  12  to the CSR file.
- csr_write_data  out  32  to the CSR file.
- pc_redirect  out  1  one-cycle pulse, load redirect_target into the PC.
- redirect_target  out  32  new PC.
- trap_stall  out  1  freeze fetch/decode.
- busy  out  1  FSM not in IDLE.

## Operation
- States: IDLE, WR_MEPC, WR_MCAUSE, JMP_MTVEC, JMP_MEPC.
- IDLE with no request:
  - core_* ports pass through to the CSR file.
  - pc_redirect=0.
- IDLE with any exc_* flag set:
  - Latch trap_pc and the encoded cause.
  - Suppress the core write in that cycle, so csr_write_enable=0.
  - Next state WR_MEPC.
- IDLE with mret and no exc_* flag: next state JMP_MEPC. Any exception outranks a simultaneous mret.
- Cause priority, highest first, with mcause value:
  - inst_misaligned 0
  - illegal 2
  - ebreak 3
  - ecall 11
  - load_misaligned 4
  - store_misaligned 6
- WR_MEPC:
  - Write 0x341 with {latched_pc[31:2],2'b00}.
  - Next state WR_MCAUSE.
- WR_MCAUSE:
  - Write 0x343 with the zero-extended cause.
  - Next state JMP_MTVEC.
- JMP_MTVEC:
  - csr_read_address=0x305, no write.
  - pc_redirect=1, redirect_target={csr_read_data[31:2],2'b00}. Direct mode only; mode bits are ignored.
  - Next state IDLE.
- JMP_MEPC:
  - csr_read_address=0x341.
  - pc_redirect=1, redirect_target={csr_read_data[31:2],2'b00}.
  - Next state IDLE.
- While not in IDLE:
  - All core_* inputs and new exc_*/mret inputs are ignored and not queued.
  - The core is responsible for holding them under trap_stall.

## Timing
- Reset (async, while reset=1):
  - State IDLE; latched pc and cause cleared.
  - csr_write_enable=0, pc_redirect=0, busy=0, trap_stall=0.
  - csr_write_address, csr_write_data and redirect_target = 0.
  - csr_read_address = core pass-through.
- Reset asserted mid-sequence aborts it immediately. No further CSR write or redirect is issued after reset releases.
- Trap flag at edge N:
  - N+1: WR_MEPC write.
  - N+2: WR_MCAUSE write.
  - N+3: JMP_MTVEC redirect.
  - N+4: IDLE.
  - Four cycles from request to PC load.
- MRET at edge N: JMP_MEPC at N+1, IDLE at N+2.
- trap_stall is combinational = busy | any exc_* | mret. It asserts in the request cycle itself.
- busy is registered, = state≠IDLE.
- All CSR writes take effect at the rising edge that ends their state.
- mcause zero-extension: [31]=0 (no interrupts), [30:4]=0.

## Structure
- Package rv32_trap_pkg holds:
  - state enum;
  - CSR address constants 0x305, 0x341, 0x343;
  - cause code constants.
- Sub-module trap_cause_encoder: combinational priority encoder from the six exc_* flags to {valid, cause[3:0]}.

## Test plan
- Reset mid-sequence: reset in WR_MCAUSE → all outputs zero, no 0x343 write after release, state IDLE.
- ecall, trap_pc=0x0000_0124, mtvec read=0x0000_1000:
  - 0x341←0x124 at N+1;
  - 0x343←11 at N+2;
  - pc_redirect with 0x1000 at N+3;
  - busy low at N+4.
- illegal+ecall+load_misaligned same cycle → mcause=2.
- Exception and mret same cycle → trap sequence only, no JMP_MEPC.
- Core write to 0x341 in the exception cycle → suppressed; only the trap write lands.
- mret with mepc=0x0000_0203 → redirect_target=0x0000_0200 one cycle later, no CSR write.
- Idle pass-through: core write 0x343←0x5 → identical values on the csr_write_* outputs in the same cycle, busy=0.

Source files
------------

// File: rtl/rv32_trap_pkg.sv
// Shared types and constants for the machine-mode trap sequencer.
// Contents: FSM state encoding, CSR addresses, mcause codes and a PC alignment helper.
package rv32_trap_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned CSR_AW  = 12;
    localparam int unsigned CAUSE_W = 4;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WR_MEPC   = 3'd1,
        WR_MCAUSE = 3'd2,
        JMP_MTVEC = 3'd3,
        JMP_MEPC  = 3'd4
    } state_t;

    localparam logic [CSR_AW-1:0] CSR_MTVEC  = 12'h305;
    localparam logic [CSR_AW-1:0] CSR_MEPC   = 12'h341;
    localparam logic [CSR_AW-1:0] CSR_MCAUSE = 12'h343;

    localparam logic [CAUSE_W-1:0] CAUSE_INST_MISALIGNED  = 4'd0;
    localparam logic [CAUSE_W-1:0] CAUSE_ILLEGAL          = 4'd2;
    localparam logic [CAUSE_W-1:0] CAUSE_EBREAK           = 4'd3;
    localparam logic [CAUSE_W-1:0] CAUSE_LOAD_MISALIGNED  = 4'd4;
    localparam logic [CAUSE_W-1:0] CAUSE_STORE_MISALIGNED = 4'd6;
    localparam logic [CAUSE_W-1:0] CAUSE_ECALL            = 4'd11;

    // Force a word-aligned PC; the low two bits never reach the PC.
    function automatic logic [XLEN-1:0] align4(input logic [XLEN-1:0] a);
        return a & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/trap_cause_encoder.sv
// Fixed-priority encoder from the synchronous exception flags to an mcause code.
module trap_cause_encoder
    import rv32_trap_pkg::*;
(
    input  logic               i_inst_misaligned,
    input  logic               i_illegal,
    input  logic               i_ebreak,
    input  logic               i_ecall,
    input  logic               i_load_misaligned,
    input  logic               i_store_misaligned,
    output logic               o_valid,
    output logic [CAUSE_W-1:0] o_cause
);

    // ecall deliberately outranks the load/store misalignment faults.
    always_comb begin
        o_valid = 1'b1;
        o_cause = CAUSE_INST_MISALIGNED;
        if (i_inst_misaligned) begin
            o_cause = CAUSE_INST_MISALIGNED;
        end else if (i_illegal) begin
            o_cause = CAUSE_ILLEGAL;
        end else if (i_ebreak) begin
            o_cause = CAUSE_EBREAK;
        end else if (i_ecall) begin
            o_cause = CAUSE_ECALL;
        end else if (i_load_misaligned) begin
            o_cause = CAUSE_LOAD_MISALIGNED;
        end else if (i_store_misaligned) begin
            o_cause = CAUSE_STORE_MISALIGNED;
        end else begin
            o_valid = 1'b0;
        end
    end

endmodule

// File: rtl/trap_controller.sv
// CSR port arbiter and trap/MRET sequencer: passes the core Zicsr port through in IDLE,
// otherwise owns the port to write mepc/mcause and fetch mtvec or mepc for the PC redirect.
module trap_controller
    import rv32_trap_pkg::*;
#(
    parameter state_t RESET_STATE = IDLE
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [CSR_AW-1:0] core_csr_read_address,
    input  logic              core_csr_write_enable,
    input  logic [CSR_AW-1:0] core_csr_write_address,
    input  logic [XLEN-1:0]   core_csr_write_data,
    input  logic [XLEN-1:0]   trap_pc,
    input  logic              exc_inst_misaligned,
    input  logic              exc_illegal,
    input  logic              exc_ebreak,
    input  logic              exc_ecall,
    input  logic              exc_load_misaligned,
    input  logic              exc_store_misaligned,
    input  logic              mret,
    input  logic [XLEN-1:0]   csr_read_data,
    output logic [CSR_AW-1:0] csr_read_address,
    output logic              csr_write_enable,
    output logic [CSR_AW-1:0] csr_write_address,
    output logic [XLEN-1:0]   csr_write_data,
    output logic              pc_redirect,
    output logic [XLEN-1:0]   redirect_target,
    output logic              trap_stall,
    output logic              busy
);

    state_t               r_state;
    state_t               w_next_state;
    logic [XLEN-1:0]      r_trap_pc;
    logic [CAUSE_W-1:0]   r_cause;
    logic                 w_exc_valid;
    logic [CAUSE_W-1:0]   w_exc_cause;

    trap_cause_encoder u_cause_enc (
        .i_inst_misaligned  (exc_inst_misaligned),
        .i_illegal          (exc_illegal),
        .i_ebreak           (exc_ebreak),
        .i_ecall            (exc_ecall),
        .i_load_misaligned  (exc_load_misaligned),
        .i_store_misaligned (exc_store_misaligned),
        .o_valid            (w_exc_valid),
        .o_cause            (w_exc_cause)
    );

    // State register plus the pc/cause captured in the request cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= RESET_STATE;
            r_trap_pc <= '0;
            r_cause   <= '0;
        end else begin
            r_state <= w_next_state;
            if (r_state == IDLE && w_exc_valid) begin
                r_trap_pc <= trap_pc;
                r_cause   <= w_exc_cause;
            end
        end
    end

    always_comb begin
        w_next_state      = r_state;
        csr_read_address  = core_csr_read_address;
        csr_write_enable  = 1'b0;
        csr_write_address = '0;
        csr_write_data    = '0;
        pc_redirect       = 1'b0;
        redirect_target   = '0;

        case (r_state)
            IDLE: begin
                csr_write_address = core_csr_write_address;
                csr_write_data    = core_csr_write_data;
                // A trapping instruction must not commit its own CSR write.
                csr_write_enable  = core_csr_write_enable & ~w_exc_valid;
                if (w_exc_valid) begin
                    w_next_state = WR_MEPC;
                end else if (mret) begin
                    w_next_state = JMP_MEPC;
                end
            end
            WR_MEPC: begin
                csr_write_enable  = 1'b1;
                csr_write_address = CSR_MEPC;
                csr_write_data    = align4(r_trap_pc);
                w_next_state      = WR_MCAUSE;
            end
            WR_MCAUSE: begin
                csr_write_enable  = 1'b1;
                csr_write_address = CSR_MCAUSE;
                csr_write_data    = XLEN'(r_cause);
                w_next_state      = JMP_MTVEC;
            end
            JMP_MTVEC: begin
                csr_read_address = CSR_MTVEC;
                pc_redirect      = 1'b1;
                redirect_target  = align4(csr_read_data);
                w_next_state     = IDLE;
            end
            JMP_MEPC: begin
                csr_read_address = CSR_MEPC;
                pc_redirect      = 1'b1;
                redirect_target  = align4(csr_read_data);
                w_next_state     = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase

        // Hold the write/redirect side quiet while reset is applied.
        if (reset) begin
            csr_write_enable  = 1'b0;
            csr_write_address = '0;
            csr_write_data    = '0;
            pc_redirect       = 1'b0;
            redirect_target   = '0;
        end
    end

    assign busy       = (r_state != IDLE);
    assign trap_stall = busy | w_exc_valid | mret;

endmodule

// File: tb/tb_trap_controller.sv
// Directed bench for trap_controller: pass-through, trap and MRET sequences, priority, reset abort.
module tb_trap_controller;

    logic        clk;
    logic        reset;
    logic [11:0] core_csr_read_address;
    logic        core_csr_write_enable;
    logic [11:0] core_csr_write_address;
    logic [31:0] core_csr_write_data;
    logic [31:0] trap_pc;
    logic        exc_inst_misaligned;
    logic        exc_illegal;
    logic        exc_ebreak;
    logic        exc_ecall;
    logic        exc_load_misaligned;
    logic        exc_store_misaligned;
    logic        mret;
    logic [31:0] csr_read_data;
    logic [11:0] csr_read_address;
    logic        csr_write_enable;
    logic [11:0] csr_write_address;
    logic [31:0] csr_write_data;
    logic        pc_redirect;
    logic [31:0] redirect_target;
    logic        trap_stall;
    logic        busy;

    int total = 0;
    int bad   = 0;

    trap_controller dut (
        .clk                    (clk),
        .reset                  (reset),
        .core_csr_read_address  (core_csr_read_address),
        .core_csr_write_enable  (core_csr_write_enable),
        .core_csr_write_address (core_csr_write_address),
        .core_csr_write_data    (core_csr_write_data),
        .trap_pc                (trap_pc),
        .exc_inst_misaligned    (exc_inst_misaligned),
        .exc_illegal            (exc_illegal),
        .exc_ebreak             (exc_ebreak),
        .exc_ecall              (exc_ecall),
        .exc_load_misaligned    (exc_load_misaligned),
        .exc_store_misaligned   (exc_store_misaligned),
        .mret                   (mret),
        .csr_read_data          (csr_read_data),
        .csr_read_address       (csr_read_address),
        .csr_write_enable       (csr_write_enable),
        .csr_write_address      (csr_write_address),
        .csr_write_data         (csr_write_data),
        .pc_redirect            (pc_redirect),
        .redirect_target        (redirect_target),
        .trap_stall             (trap_stall),
        .busy                   (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one cycle, then leave 1 ns for inputs to be driven after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // flags = {store, load, ecall, ebreak, illegal, inst}
    task automatic set_exc(input logic [5:0] flags);
        exc_inst_misaligned  = flags[0];
        exc_illegal          = flags[1];
        exc_ebreak           = flags[2];
        exc_ecall            = flags[3];
        exc_load_misaligned  = flags[4];
        exc_store_misaligned = flags[5];
    endtask

    // Full trap sequence; caller is already 1 ns after an edge in IDLE.
    task automatic run_trap(input string tag, input logic [5:0] flags, input logic m,
                            input logic [31:0] pc, input logic [31:0] mtvec,
                            input logic [31:0] exp_mepc, input logic [31:0] exp_cause,
                            input logic [31:0] exp_target);
        set_exc(flags);
        mret    = m;
        trap_pc = pc;
        #3;
        chk({tag, "_req_we"},    32'(csr_write_enable), 32'd0);
        chk({tag, "_req_stall"}, 32'(trap_stall), 32'd1);
        chk({tag, "_req_busy"},  32'(busy), 32'd0);
        step();
        set_exc(6'b0);
        mret    = 1'b0;
        trap_pc = 32'hFFFF_FFFF;
        #3;
        chk({tag, "_mepc_we"},    32'(csr_write_enable), 32'd1);
        chk({tag, "_mepc_addr"},  32'(csr_write_address), 32'h341);
        chk({tag, "_mepc_data"},  csr_write_data, exp_mepc);
        chk({tag, "_mepc_busy"},  32'(busy), 32'd1);
        chk({tag, "_mepc_stall"}, 32'(trap_stall), 32'd1);
        step();
        #3;
        chk({tag, "_mcause_we"},   32'(csr_write_enable), 32'd1);
        chk({tag, "_mcause_addr"}, 32'(csr_write_address), 32'h343);
        chk({tag, "_mcause_data"}, csr_write_data, exp_cause);
        chk({tag, "_mcause_redir"}, 32'(pc_redirect), 32'd0);
        step();
        csr_read_data = mtvec;
        #3;
        chk({tag, "_jmp_raddr"},  32'(csr_read_address), 32'h305);
        chk({tag, "_jmp_redir"},  32'(pc_redirect), 32'd1);
        chk({tag, "_jmp_target"}, redirect_target, exp_target);
        chk({tag, "_jmp_we"},     32'(csr_write_enable), 32'd0);
        step();
        core_csr_write_enable = 1'b0;
        #3;
        chk({tag, "_done_busy"},  32'(busy), 32'd0);
        chk({tag, "_done_redir"}, 32'(pc_redirect), 32'd0);
        chk({tag, "_done_stall"}, 32'(trap_stall), 32'd0);
    endtask

    initial begin
        reset                  = 1'b1;
        core_csr_read_address  = 12'h0AB;
        core_csr_write_enable  = 1'b1;
        core_csr_write_address = 12'h343;
        core_csr_write_data    = 32'h5;
        trap_pc                = '0;
        mret                   = 1'b0;
        csr_read_data          = '0;
        set_exc(6'b0);

        // Reset values, with a core write pending that must stay hidden
        #3;
        chk("rst_we",     32'(csr_write_enable), 32'd0);
        chk("rst_waddr",  32'(csr_write_address), 32'd0);
        chk("rst_wdata",  csr_write_data, 32'd0);
        chk("rst_redir",  32'(pc_redirect), 32'd0);
        chk("rst_target", redirect_target, 32'd0);
        chk("rst_busy",   32'(busy), 32'd0);
        chk("rst_stall",  32'(trap_stall), 32'd0);
        chk("rst_raddr",  32'(csr_read_address), 32'h0AB);

        // Idle pass-through of the core write 0x343 <- 5
        step();
        reset = 1'b0;
        core_csr_read_address = 12'h305;
        #3;
        chk("pt_we",    32'(csr_write_enable), 32'd1);
        chk("pt_waddr", 32'(csr_write_address), 32'h343);
        chk("pt_wdata", csr_write_data, 32'h5);
        chk("pt_raddr", 32'(csr_read_address), 32'h305);
        chk("pt_busy",  32'(busy), 32'd0);

        // ecall with a core write to mepc held across the whole sequence
        step();
        core_csr_write_enable  = 1'b1;
        core_csr_write_address = 12'h341;
        core_csr_write_data    = 32'hDEAD_BEEF;
        run_trap("ecall", 6'b001000, 1'b0, 32'h0000_0124, 32'h0000_1000,
                 32'h0000_0124, 32'd11, 32'h0000_1000);

        // illegal + ecall + load_misaligned: illegal wins; misaligned pc and mtvec mode bits dropped
        run_trap("prio", 6'b011010, 1'b0, 32'h0000_0127, 32'h0000_2003,
                 32'h0000_0124, 32'd2, 32'h0000_2000);

        // exception with simultaneous mret: trap only, mret not queued
        run_trap("excmret", 6'b000010, 1'b1, 32'h0000_0400, 32'h0000_3000,
                 32'h0000_0400, 32'd2, 32'h0000_3000);

        run_trap("inst", 6'b111111, 1'b0, 32'h8000_0010, 32'h0000_0100,
                 32'h8000_0010, 32'd0, 32'h0000_0100);
        run_trap("store", 6'b100000, 1'b0, 32'h0000_0008, 32'h0000_0104,
                 32'h0000_0008, 32'd6, 32'h0000_0104);
        run_trap("load", 6'b110000, 1'b0, 32'h0000_000C, 32'h0000_0108,
                 32'h0000_000C, 32'd4, 32'h0000_0108);
        run_trap("ebreak", 6'b111100, 1'b0, 32'h0000_0010, 32'h0000_010C,
                 32'h0000_0010, 32'd3, 32'h0000_010C);

        // mret alone with mepc = 0x203
        mret = 1'b1;
        #3;
        chk("mret_req_stall", 32'(trap_stall), 32'd1);
        chk("mret_req_busy",  32'(busy), 32'd0);
        step();
        mret          = 1'b0;
        csr_read_data = 32'h0000_0203;
        #3;
        chk("mret_raddr",  32'(csr_read_address), 32'h341);
        chk("mret_redir",  32'(pc_redirect), 32'd1);
        chk("mret_target", redirect_target, 32'h0000_0200);
        chk("mret_we",     32'(csr_write_enable), 32'd0);
        chk("mret_busy",   32'(busy), 32'd1);
        step();
        #3;
        chk("mret_done_busy",  32'(busy), 32'd0);
        chk("mret_done_redir", 32'(pc_redirect), 32'd0);

        // Reset asserted while in WR_MCAUSE aborts the sequence
        step();
        exc_ecall = 1'b1;
        trap_pc   = 32'h0000_0500;
        step();
        exc_ecall = 1'b0;
        #3;
        chk("abort_in_mepc", 32'(csr_write_address), 32'h341);
        step();
        reset = 1'b1;
        #3;
        chk("abort_we",     32'(csr_write_enable), 32'd0);
        chk("abort_waddr",  32'(csr_write_address), 32'd0);
        chk("abort_wdata",  csr_write_data, 32'd0);
        chk("abort_redir",  32'(pc_redirect), 32'd0);
        chk("abort_target", redirect_target, 32'd0);
        chk("abort_busy",   32'(busy), 32'd0);
        chk("abort_stall",  32'(trap_stall), 32'd0);
        step();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #3;
            chk("post_we",    32'(csr_write_enable), 32'd0);
            chk("post_redir", 32'(pc_redirect), 32'd0);
            chk("post_busy",  32'(busy), 32'd0);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
